// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions,
// handshake FSM states and the iterative engine's operating mode.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0111;
    localparam logic [3:0] OP_SWP = 4'b1000;

    localparam int FLG_O     = 0;
    localparam int FLG_Z     = 1;
    localparam int FLG_N     = 2;
    localparam int FLG_DZ    = 3;
    localparam int FLG_ILL   = 4;
    localparam int NUM_FLAGS = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    typedef enum logic {
        MD_MUL,
        MD_DIV
    } md_mode_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Unsigned iterative engine: shift-add multiply or restoring divide, one bit
// per step. MUL leaves {o_hi,o_lo} = product; DIV leaves o_lo = quotient, o_hi = remainder.
module seq_muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  md_mode_t         i_mode,
    input  logic [WIDTH-1:0] i_a_mag,
    input  logic [WIDTH-1:0] i_b_mag,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_last
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    md_mode_t         r_mode;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ge;

    // The carry out of the partial-product add is the extra accumulator bit
    // that is shifted down into r_hi each step.
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_div_shift = {r_hi, r_lo[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_b};
        w_div_ge    = (w_div_shift >= {1'b0, r_b});
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours.
        if (!rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_mode <= MD_MUL;
        end else if (i_load) begin
            r_hi   <= '0;
            r_lo   <= i_a_mag;
            r_b    <= i_b_mag;
            r_cnt  <= '0;
            r_mode <= i_mode;
        end else if (i_step) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_mode == MD_MUL) begin
                {r_hi, r_lo} <= {w_mul_sum, r_lo[WIDTH-1:1]};
            end else begin
                r_hi <= w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], w_div_ge};
            end
        end
    end

    assign o_lo   = r_lo;
    assign o_hi   = r_hi;
    assign o_last = i_step && (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle signed ALU with start/done handshake. Owns the handshake FSM,
// operand sign handling and status flags; iteration is delegated to the core.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           functCode,
    input  logic [WIDTH-1:0]     op1,
    input  logic [WIDTH-1:0]     op2,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [WIDTH-1:0]     remainder,
    output logic [NUM_FLAGS-1:0] flags
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int MSB   = WIDTH - 1;

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_op;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic [WIDTH-1:0]       r_result;
    logic [WIDTH-1:0]       r_remainder;
    logic [NUM_FLAGS-1:0]   r_flags;

    logic                   w_load;
    logic                   w_step;
    logic                   w_wr;
    md_mode_t               w_mode;
    logic [WIDTH-1:0]       w_res;
    logic [WIDTH-1:0]       w_rem;
    logic                   w_o;
    logic                   w_dz;
    logic                   w_ill;
    logic [2*WIDTH-1:0]     w_prod;

    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic [WIDTH-1:0]       w_core_lo;
    logic [WIDTH-1:0]       w_core_hi;
    logic                   w_core_last;

    // |MIN| wraps to 2^(WIDTH-1), which is exact when read as unsigned.
    assign w_a_mag = op1[MSB] ? (~op1 + 1'b1) : op1;
    assign w_b_mag = op2[MSB] ? (~op2 + 1'b1) : op2;

    seq_muldiv_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_mode  (w_mode),
        .i_a_mag (w_a_mag),
        .i_b_mag (w_b_mag),
        .o_lo    (w_core_lo),
        .o_hi    (w_core_hi),
        .o_last  (w_core_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement can leave one unassigned (latch).
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        w_mode = MD_MUL;
        w_wr   = 1'b0;
        w_res  = '0;
        w_rem  = '0;
        w_o    = 1'b0;
        w_dz   = 1'b0;
        w_ill  = 1'b0;
        w_prod = '0;
        case (r_state)
            S_IDLE: if (start) begin
                w_next = S_DONE;
                w_wr   = 1'b1;
                case (functCode)
                    OP_ADD: begin
                        w_res = op1 + op2;
                        w_o   = (op1[MSB] == op2[MSB]) && (w_res[MSB] != op1[MSB]);
                    end
                    OP_SUB: begin
                        w_res = op1 - op2;
                        w_o   = (op1[MSB] != op2[MSB]) && (w_res[MSB] != op1[MSB]);
                    end
                    OP_MUL: begin
                        w_wr   = 1'b0;
                        w_load = 1'b1;
                        w_next = S_ITER;
                    end
                    OP_DIV: begin
                        if (op2 == '0) begin
                            w_dz  = 1'b1;
                            w_res = '1;
                            w_rem = op1;
                        end else begin
                            w_wr   = 1'b0;
                            w_load = 1'b1;
                            w_mode = MD_DIV;
                            w_next = S_ITER;
                        end
                    end
                    OP_MOV: w_res = op1;
                    OP_SWP: begin
                        w_res = op2;
                        w_rem = op1;
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            S_ITER: begin
                w_step = 1'b1;
                if (w_core_last) w_next = S_FIX;
            end
            S_FIX: begin
                w_wr   = 1'b1;
                w_next = S_DONE;
                if (r_op == OP_MUL) begin
                    w_prod = {w_core_hi, w_core_lo};
                    if (r_neg_q) w_prod = -w_prod;
                    w_res = w_prod[WIDTH-1:0];
                    w_rem = w_prod[2*WIDTH-1:WIDTH];
                    w_o   = (w_rem != {WIDTH{w_res[MSB]}});
                end else begin
                    w_res = r_neg_q ? -w_core_lo : w_core_lo;
                    w_rem = r_neg_r ? -w_core_hi : w_core_hi;
                    // Only MIN / -1 yields a positive quotient with the MSB set.
                    w_o   = !r_neg_q && w_core_lo[MSB];
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op        <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_result    <= '0;
            r_remainder <= '0;
            r_flags     <= '0;
        end else begin
            if (w_load) begin
                r_op    <= functCode;
                r_neg_q <= op1[MSB] ^ op2[MSB];
                r_neg_r <= op1[MSB];
            end
            if (w_wr) begin
                r_result             <= w_res;
                r_remainder          <= w_rem;
                r_flags[FLG_O]       <= w_o;
                r_flags[FLG_Z]       <= (w_res == '0);
                r_flags[FLG_N]       <= w_res[MSB];
                r_flags[FLG_DZ]      <= w_dz;
                r_flags[FLG_ILL]     <= w_ill;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign remainder = r_remainder;
    assign flags     = r_flags;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu; an arithmetic reference model
// predicts every result, flag set and done latency.
module tb_seq_alu;

    localparam int     W    = 16;
    localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (W - 1));

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   functCode;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] remainder;
    logic [4:0]   flags;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .functCode (functCode),
        .op1       (op1),
        .op2       (op2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .flags     (flags)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expectation shared between driver and compare process.
    bit           chk_en = 1'b0;
    bit           pend   = 1'b0;
    bit           inject = 1'b0;
    logic [W-1:0] e_res, e_rem, h_res, h_rem;
    logic [4:0]   e_fl, h_fl;
    int           e_done_cyc;
    int           done_at;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain signed integer arithmetic on 64-bit values.
    function automatic void model(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] res, output logic [W-1:0] rem,
                                  output logic [4:0] fl, output int lat);
        longint sa, sb, full, r;
        bit o, dz, ill;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0; rem = '0; o = 1'b0; dz = 1'b0; ill = 1'b0; lat = 1;
        case (f)
            4'h0: begin full = sa + sb; res = full[W-1:0]; o = (full > MAXV) || (full < MINV); end
            4'h1: begin full = sa - sb; res = full[W-1:0]; o = (full > MAXV) || (full < MINV); end
            4'h4: begin
                full = sa * sb;
                res  = full[W-1:0];
                rem  = full[2*W-1:W];
                o    = (full > MAXV) || (full < MINV);
                lat  = W + 2;
            end
            4'h5: begin
                if (sb == 0) begin
                    res = '1; rem = a; dz = 1'b1;
                end else begin
                    full = sa / sb;
                    r    = sa % sb;
                    res  = full[W-1:0];
                    rem  = r[W-1:0];
                    o    = (full > MAXV);
                    lat  = W + 2;
                end
            end
            4'h7: res = a;
            4'h8: begin res = b; rem = a; end
            default: ill = 1'b1;
        endcase
        fl = {ill, dz, res[W-1], (res == '0), o};
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 9))
            0: return '0;
            1: return {1'b1, {(W-1){1'b0}}};
            2: return '1;
            3: return {1'b0, {(W-1){1'b1}}};
            4: return W'(1);
            5: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic [3:0] rnd_opcode();
        case ($urandom_range(0, 13))
            0, 1:    return 4'h0;
            2, 3:    return 4'h1;
            4, 5, 6: return 4'h4;
            7, 8, 9: return 4'h5;
            10:      return 4'h7;
            11:      return 4'h8;
            default: return 4'($urandom);
        endcase
    endfunction

    // Compare process: while an op is in flight busy must be high and done
    // must rise exactly at the predicted cycle; otherwise outputs must hold.
    always @(negedge clk) begin
        if (chk_en) begin
            if (pend) begin
                check("busy_in_flight", busy, 1);
                check("done_timing", done, cyc == e_done_cyc);
                if (cyc >= e_done_cyc) begin
                    check("result", result, e_res);
                    check("remainder", remainder, e_rem);
                    check("flags", flags, e_fl);
                    h_res   = e_res;
                    h_rem   = e_rem;
                    h_fl    = e_fl;
                    done_at = cyc;
                    pend    = 1'b0;
                end
            end else begin
                check("busy_idle", busy, 0);
                check("done_idle", done, 0);
                check("result_hold", result, h_res);
                check("remainder_hold", remainder, h_rem);
                check("flags_hold", flags, h_fl);
            end
        end
    end

    task automatic issue(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r, m;
        logic [4:0]   fl;
        int           lat;
        @(negedge clk);
        start = 1'b1; functCode = f; op1 = a; op2 = b;
        model(f, a, b, r, m, fl, lat);
        @(posedge clk);
        #1;
        start = 1'b0; functCode = 4'($urandom); op1 = W'($urandom); op2 = W'($urandom);
        e_res = r; e_rem = m; e_fl = fl;
        e_done_cyc = cyc + lat - 1;
        pend = 1'b1;
    endtask

    // Waits for the compare process to retire the op; optionally pulses
    // junk starts while busy, which the DUT must ignore.
    task automatic wait_done();
        int k = 0;
        while (pend && k < 200) begin
            @(negedge clk);
            k++;
            if (pend && inject && $urandom_range(0, 4) == 0) begin
                start = 1'b1; functCode = rnd_opcode(); op1 = rnd_operand(); op2 = rnd_operand();
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_seen_before_timeout", pend, 0);
        pend = 1'b0;
    endtask

    task automatic run_dir(input string name, input logic [3:0] f, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] xr, input logic [W-1:0] xm,
                           input logic [4:0] xf, input int xlat);
        int c0;
        issue(f, a, b);
        c0 = cyc;
        wait_done();
        check({name, "_result"}, result, xr);
        check({name, "_remainder"}, remainder, xm);
        check({name, "_flags"}, flags, xf);
        check({name, "_latency"}, done_at - c0 + 1, xlat);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; functCode = '0; op1 = '0; op2 = '0;
        h_res = '0; h_rem = '0; h_fl = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_remainder", remainder, 0);
        check("reset_flags", flags, 0);
        rst = 1'b1;
        chk_en = 1'b1;

        // Flags are {ill, dz, n, z, o}.
        run_dir("add_ovf",  4'h0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 5'b00101, 1);
        run_dir("sub_zero", 4'h1, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 5'b00010, 1);
        run_dir("mul_ovf",  4'h4, 16'd300,  16'hFF38, 16'h15A0, 16'hFFFF, 5'b00001, 18);
        run_dir("mul_neg",  4'h4, 16'd7,    16'hFFFD, 16'hFFEB, 16'hFFFF, 5'b00100, 18);
        run_dir("div_neg",  4'h5, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 5'b00100, 18);
        run_dir("div_min",  4'h5, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 5'b00101, 18);
        run_dir("div_zero", 4'h5, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 5'b01100, 1);
        run_dir("illegal",  4'hF, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 5'b10010, 1);
        run_dir("swap",     4'h8, 16'h1234, 16'hABCD, 16'hABCD, 16'h1234, 5'b00100, 1);
        run_dir("move",     4'h7, 16'h8001, 16'h0000, 16'h8001, 16'h0000, 5'b00100, 1);

        // Start pulses during an in-flight MUL must be ignored.
        inject = 1'b1;
        run_dir("mul_busy", 4'h4, 16'hFF9C, 16'hFF9C, 16'h2710, 16'h0000, 5'b00000, 18);

        // Reset in the middle of a divide: discarded, no done pulse.
        inject = 1'b0;
        issue(4'h5, 16'h1234, 16'h0007);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        pend = 1'b0;
        h_res = '0; h_rem = '0; h_fl = '0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_result", result, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_flags", flags, 0);
        repeat (20) @(negedge clk);
        run_dir("add_after_rst", 4'h0, 16'h0003, 16'h0004, 16'h0007, 16'h0000, 5'b00000, 1);

        inject = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(rnd_opcode(), rnd_operand(), rnd_operand());
            wait_done();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
